// File: rtl/llc_mem_responder_pkg.sv
// llc_mem_responder_pkg: shared cache constants, line/word/address types and beat address helper
package llc_mem_responder_pkg;
  localparam int ADDR_BITS      = 32;
  localparam int BITS_PER_WORD  = 64;
  localparam int WORDS_PER_LINE = 4;
  localparam int BYTE_BITS      = $clog2(BITS_PER_WORD / 8);
  localparam int WORD_IDX_BITS  = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_BITS    = BYTE_BITS + WORD_IDX_BITS;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int LINE_BITS      = BITS_PER_WORD * WORDS_PER_LINE;
  localparam int CNT_BITS       = WORD_IDX_BITS + 1;
  typedef logic [LINE_BITS-1:0]      line_t;
  typedef logic [BITS_PER_WORD-1:0]  word_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [1:0]                hprot_t;
  typedef logic [CNT_BITS-1:0]       cnt_t;
  localparam cnt_t CNT_FULL = cnt_t'(WORDS_PER_LINE);
  localparam cnt_t CNT_LAST = cnt_t'(WORDS_PER_LINE - 1);
  function automatic logic [ADDR_BITS-1:0] beat_addr(input line_addr_t a, input logic [WORD_IDX_BITS-1:0] i);
    return {a, i, {BYTE_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/llc_mem_line_asm.sv
// llc_mem_line_asm: word-indexed line register; wr stores wdata at the next slot, clr rewinds the slot count, full when all words written, line is the assembled line
module llc_mem_line_asm
  import llc_mem_responder_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr,
  input  logic  clr,
  input  word_t wdata,
  output line_t line,
  output logic  full
);
  logic [WORDS_PER_LINE-1:0][BITS_PER_WORD-1:0] words;
  cnt_t cnt;
  assign full = cnt == CNT_FULL;
  assign line = words;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      words <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wr && !full) begin
      words[cnt[WORD_IDX_BITS-1:0]] <= wdata;
      cnt <= cnt + cnt_t'(1);
    end
  end
endmodule

// File: rtl/llc_mem_responder.sv
// llc_mem_responder: serialises LLC line requests (llc_mem_req_*) into word beats on the backing port (mem_*), returns read lines on llc_mem_rsp_*, err flags stray read returns
module llc_mem_responder
  import llc_mem_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  llc_mem_req_valid,
  output logic                  llc_mem_req_ready,
  input  logic                  llc_mem_req_hwrite,
  input  logic [2:0]            llc_mem_req_hsize,
  input  hprot_t                llc_mem_req_hprot,
  input  line_addr_t            llc_mem_req_addr,
  input  line_t                 llc_mem_req_line,
  output logic                  llc_mem_rsp_valid,
  input  logic                  llc_mem_rsp_ready,
  output line_t                 llc_mem_rsp_line,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output hprot_t                mem_hprot,
  output word_t                 mem_wdata,
  input  logic                  mem_rvalid,
  input  word_t                 mem_rdata,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RET, RSP} state_t;
  state_t state, state_n;
  cnt_t issue_cnt;
  hprot_t hprot_q;
  line_addr_t addr_q;
  logic [WORDS_PER_LINE-1:0][BITS_PER_WORD-1:0] wline_q;
  logic beat_go, last_beat, ret_ok, full, asm_clr, unused_ok;
  assign beat_go   = mem_valid && mem_ready;
  assign last_beat = beat_go && issue_cnt == CNT_LAST;
  assign ret_ok    = mem_rvalid && (state == READ || state == WAIT_RET) && !full;
  assign asm_clr   = state == WAIT_RET && full;
  assign mem_addr  = beat_addr(addr_q, issue_cnt[WORD_IDX_BITS-1:0]);
  assign mem_wdata = wline_q[issue_cnt[WORD_IDX_BITS-1:0]];
  assign mem_hprot = hprot_q;
  assign unused_ok = ^llc_mem_req_hsize;
  llc_mem_line_asm u_asm (
    .clk   (clk),
    .rst   (rst),
    .wr    (ret_ok),
    .clr   (asm_clr),
    .wdata (mem_rdata),
    .line  (llc_mem_rsp_line),
    .full  (full)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = llc_mem_req_valid ? (llc_mem_req_hwrite ? WRITE : READ) : IDLE;
      WRITE:    state_n = last_beat ? IDLE : WRITE;
      READ:     state_n = last_beat ? WAIT_RET : READ;
      WAIT_RET: state_n = full ? RSP : WAIT_RET;
      RSP:      state_n = llc_mem_rsp_ready ? IDLE : RSP;
      default:  state_n = IDLE;
    endcase
    llc_mem_req_ready = !rst && state == IDLE;
    llc_mem_rsp_valid = !rst && state == RSP;
    mem_valid         = !rst && (state == WRITE || state == READ);
    mem_we            = !rst && state == WRITE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      hprot_q   <= '0;
      addr_q    <= '0;
      wline_q   <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      if (llc_mem_req_valid && llc_mem_req_ready) begin
        hprot_q <= llc_mem_req_hprot;
        addr_q  <= llc_mem_req_addr;
        wline_q <= llc_mem_req_line;
      end
      if (beat_go) issue_cnt <= last_beat ? '0 : issue_cnt + cnt_t'(1);
      if (mem_rvalid && !ret_ok) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_llc_mem_responder.sv
// tb_llc_mem_responder: directed tests with a transaction-level model checked every cycle
module tb_llc_mem_responder;
  import llc_mem_responder_pkg::*;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_hwrite = 0, rsp_valid, rsp_ready = 1;
  logic [2:0] req_hsize = 3'd5;
  hprot_t req_hprot = 0, m_hprot;
  line_addr_t req_addr = 0;
  line_t req_line = 0, rsp_line;
  logic m_valid, m_ready = 1, m_we, m_rvalid = 0, err;
  logic [ADDR_BITS-1:0] m_addr;
  word_t m_wdata, m_rdata = 0;
  always #5 clk = ~clk;
  llc_mem_responder dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(req_valid), .llc_mem_req_ready(req_ready), .llc_mem_req_hwrite(req_hwrite),
    .llc_mem_req_hsize(req_hsize), .llc_mem_req_hprot(req_hprot), .llc_mem_req_addr(req_addr),
    .llc_mem_req_line(req_line), .llc_mem_rsp_valid(rsp_valid), .llc_mem_rsp_ready(rsp_ready),
    .llc_mem_rsp_line(rsp_line), .mem_valid(m_valid), .mem_ready(m_ready), .mem_we(m_we),
    .mem_addr(m_addr), .mem_hprot(m_hprot), .mem_wdata(m_wdata), .mem_rvalid(m_rvalid),
    .mem_rdata(m_rdata), .err(err)
  );
  typedef struct { logic [31:0] addr; logic we; logic [63:0] wdata; logic [1:0] hprot; } beat_t;
  typedef struct { int due; logic [63:0] data; } ret_t;
  beat_t beats[$];
  ret_t ret_q[$];
  logic [63:0] rd_src[$], wdata_log[$];
  logic [31:0] addr_log[$];
  int checks = 0, failures = 0, cyc = 0, lat = 1, rsp_count = 0, rsp_delay = 0, rd_got = 0;
  int accept_cyc = 0, rsp_cyc = 0;
  bit rd_active = 0, rsp_pend = 0, m_err = 0, ready_toggle = 0, stray_req = 0, rsp_seen = 0;
  line_t exp_line = 0, last_line = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      ret_q.delete();
      m_rvalid = 0;
      m_rdata = 0;
      m_ready = 1;
    end else begin
      m_ready = ready_toggle ? !m_ready : 1'b1;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        m_rvalid = 1;
        m_rdata = ret_q[0].data;
        void'(ret_q.pop_front());
      end else if (stray_req) begin
        m_rvalid = 1;
        m_rdata = 64'hBAD;
        stray_req = 0;
      end else begin
        m_rvalid = 0;
        m_rdata = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      beats.delete();
      rd_active = 0; rsp_pend = 0; rsp_delay = 0; rd_got = 0; m_err = 0;
    end else begin
      bit idle;
      ret_t r;
      beat_t b;
      if (rsp_delay > 0) begin
        rsp_delay--;
        if (rsp_delay == 0) rsp_pend = 1;
      end
      idle = beats.size() == 0 && !rd_active && !rsp_pend && rsp_delay == 0;
      chk("req_ready", req_ready, idle);
      chk("mem_valid", m_valid, beats.size() > 0);
      if (beats.size() > 0) begin
        chk("mem_addr", m_addr, beats[0].addr);
        chk("mem_we", m_we, beats[0].we);
        chk("mem_hprot", m_hprot, beats[0].hprot);
        if (beats[0].we) chk("mem_wdata", m_wdata, beats[0].wdata);
      end
      chk("rsp_valid", rsp_valid, rsp_pend);
      if (rsp_pend) chk("rsp_line", rsp_line, exp_line);
      chk("err", err, m_err);
      if (beats.size() > 0 && m_ready) begin
        if (!beats[0].we) begin
          r.due = cyc + lat;
          r.data = rd_src.size() > 0 ? rd_src.pop_front() : 64'(cyc);
          ret_q.push_back(r);
        end else wdata_log.push_back(m_wdata);
        addr_log.push_back(m_addr);
        void'(beats.pop_front());
      end
      if (m_rvalid) begin
        if (rd_active && rd_got < 4) begin
          exp_line[rd_got*64 +: 64] = m_rdata;
          rd_got++;
          if (rd_got == 4) begin
            rd_active = 0;
            rsp_delay = 2;
          end
        end else m_err = 1;
      end
      if (rsp_pend && rsp_ready) begin
        rsp_pend = 0;
        rsp_count++;
        last_line = rsp_line;
      end
      if (idle && req_valid) begin
        for (int i = 0; i < 4; i++) begin
          b.addr = 32'(req_addr) * 32 + 32'(i * 8);
          b.we = req_hwrite;
          b.wdata = req_line[i*64 +: 64];
          b.hprot = req_hprot;
          beats.push_back(b);
        end
        if (!req_hwrite) begin
          rd_active = 1;
          rd_got = 0;
        end
        accept_cyc = cyc + 1;
        rsp_seen = 0;
      end
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1;
        rsp_cyc = cyc;
      end
    end
  end
  task automatic send(input logic we, input line_addr_t a, input line_t l, input hprot_t p);
    int n = 0;
    req_valid = 1; req_hwrite = we; req_addr = a; req_line = l; req_hprot = p;
    while (1) begin
      @(negedge clk);
      if (req_ready || n > 100) break;
      n++;
    end
    if (n > 100) begin
      failures++;
      $display("FAIL send_timeout actual=%0d required=<100", n);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic wait_cnt(input int target);
    int n = 0;
    while (rsp_count < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", rsp_count, target);
    @(posedge clk); #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_ready && beats.size() == 0) && n < 200);
    chk("idle_wait", req_ready, 1);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int c0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_valid", m_valid, 0);
    chk("rst_mem_we", m_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", m_addr, 0);
    chk("rst_mem_wdata", m_wdata, 0);
    chk("rst_rsp_line", rsp_line, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    @(posedge clk); #1;
    // basic read, zero-wait memory
    addr_log.delete();
    rd_src = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    send(0, 27'h2000, 0, 2'b01);
    wait_cnt(1);
    chk("rd_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rd_addr%0d", i), addr_log.size() > i ? addr_log[i] : 32'hFFFFFFFF, 32'h40000 + 32'(i * 8));
    chk("rd_latency", rsp_cyc - accept_cyc, 6);
    chk("rd_line", last_line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    // write with stalls on the memory port
    addr_log.delete();
    wdata_log.delete();
    ready_toggle = 1;
    send(1, 27'h0123, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 2'b10);
    wait_idle();
    ready_toggle = 0;
    chk("wr_beats", wdata_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_data%0d", i), wdata_log.size() > i ? wdata_log[i] : 64'hFFFF, 64'hD0 + 64'(i));
      chk($sformatf("wr_addr%0d", i), addr_log.size() > i ? addr_log[i] : 32'hFFFFFFFF, 32'h2460 + 32'(i * 8));
    end
    chk("wr_no_rsp", rsp_count, 1);
    // read held by rsp_ready low
    rsp_ready = 0;
    rd_src = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
    send(0, 27'h55, 0, 2'b11);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_line", rsp_line, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    wait_cnt(2);
    // slow returns overlapping issue
    lat = 3;
    rd_src = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
    send(0, 27'h77, 0, 2'b00);
    wait_cnt(3);
    lat = 1;
    chk("slow_line", last_line, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    repeat (10) @(negedge clk);
    chk("slow_single_rsp", rsp_count, 3);
    @(posedge clk); #1;
    // stray return in IDLE
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("stray_err", err, 1);
    @(posedge clk); #1;
    rd_src = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
    send(0, 27'h31, 0, 2'b01);
    wait_cnt(4);
    chk("err_sticky", err, 1);
    chk("after_err_line", last_line, {64'hE3, 64'hE2, 64'hE1, 64'hE0});
    // back-to-back write then read
    c0 = rsp_count;
    send(1, 27'h10, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 2'b10);
    rd_src = '{64'h70, 64'h71, 64'h72, 64'h73};
    send(0, 27'h11, 0, 2'b01);
    wait_cnt(c0 + 1);
    repeat (10) @(negedge clk);
    chk("b2b_one_rsp", rsp_count, c0 + 1);
    chk("b2b_line", last_line, {64'h73, 64'h72, 64'h71, 64'h70});
    @(posedge clk); #1;
    // reset in the middle of a read
    c0 = rsp_count;
    rd_src = '{64'h90, 64'h91, 64'h92, 64'h93};
    send(0, 27'h99, 0, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_mem_valid", m_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    rd_src.delete();
    @(negedge clk);
    chk("postrst_err", err, 0);
    chk("postrst_mem_valid", m_valid, 0);
    chk("postrst_mem_we", m_we, 0);
    chk("postrst_rsp_valid", rsp_valid, 0);
    chk("postrst_mem_addr", m_addr, 0);
    chk("postrst_rsp_line", rsp_line, 0);
    chk("postrst_req_ready", req_ready, 1);
    repeat (10) @(negedge clk);
    chk("postrst_no_rsp", rsp_count, c0);
    @(posedge clk); #1;
    rd_src = '{64'h11, 64'h12, 64'h13, 64'h14};
    send(0, 27'h1, 0, 2'b01);
    wait_cnt(c0 + 1);
    chk("final_line", last_line, {64'h14, 64'h13, 64'h12, 64'h11});
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
